// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding and cell read/write codes for mem_access_ctrl
// Contents: controller state constants and enum, cell_rw encodings.
package mem_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCESS = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_RDCAP  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_ACCESS = S_ACCESS,
        ST_VERIFY = S_VERIFY,
        ST_RDCAP  = S_RDCAP,
        ST_RESP   = S_RESP
    } state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response handshake bundle for mem_access_ctrl
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata (request channel),
//          rsp_valid/rsp_ready/rsp_rdata/rsp_err (response channel).
// Modports: master = requester side, slave = controller side.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/row_decoder.sv
// rtl/row_decoder.sv - combinational address to one-hot row select decoder
// Ports: addr (ADDR_W in), onehot (2**ADDR_W out, exactly one bit set).
module row_decoder #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   onehot
);
    always_comb begin
        onehot       = '0;
        onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding read/write sequencer in front of the bit-cell array
// Ports: clk, rst (sync, active-high); bus (mem_access_ctrl_if.slave request/response);
//        cell_select/cell_rw/cell_in (registered array drive); cell_out (OR of row outputs).
// Optional: MEM_ACCESS_VERIFY_EN adds a read-back of every write and drives rsp_err.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_ctrl_if.slave      bus,
    output logic [2**ADDR_W-1:0]  cell_select,
    output logic                  cell_rw,
    output logic [DATA_W-1:0]     cell_in,
    input  logic [DATA_W-1:0]     cell_out
);
    localparam int ROWS = 2**ADDR_W;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ROWS-1:0]   sel_q, sel_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] in_q, in_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ROWS-1:0]   addr_onehot;

`ifdef MEM_ACCESS_VERIFY_EN
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
`endif

    row_decoder #(.ADDR_W(ADDR_W)) u_row_decoder (
        .addr   (bus.req_addr),
        .onehot (addr_onehot)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rw_d    = rw_q;
        in_d    = in_q;
        rdata_d = rdata_q;
`ifdef MEM_ACCESS_VERIFY_EN
        wdata_d = wdata_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    sel_d   = addr_onehot;
                    rw_d    = bus.req_we ? RW_WRITE : RW_READ;
                    in_d    = bus.req_wdata;
`ifdef MEM_ACCESS_VERIFY_EN
                    wdata_d = bus.req_wdata;
`endif
                    state_d = ST_ACCESS;
                end
            end
            // The edge leaving ACCESS is the one on which the cells act.
            ST_ACCESS: begin
                if (we_q) begin
`ifdef MEM_ACCESS_VERIFY_EN
                    // Row stays selected so the next edge reads back what was just written.
                    rw_d    = RW_READ;
                    state_d = ST_VERIFY;
`else
                    sel_d   = '0;
                    in_d    = '0;
                    state_d = ST_RESP;
`endif
                end else begin
                    sel_d   = '0;
                    state_d = ST_RDCAP;
                end
            end
`ifdef MEM_ACCESS_VERIFY_EN
            ST_VERIFY: begin
                sel_d   = '0;
                state_d = ST_RDCAP;
            end
`endif
            // Cells registered their output on the previous edge, so cell_out is valid now.
            ST_RDCAP: begin
                if (we_q) begin
                    rdata_d = '0;
`ifdef MEM_ACCESS_VERIFY_EN
                    err_d   = (cell_out != wdata_q);
`endif
                end else begin
                    rdata_d = cell_out;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rdata_d = '0;
`ifdef MEM_ACCESS_VERIFY_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sel_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rw_q    <= RW_READ;
            in_q    <= '0;
            rdata_q <= '0;
`ifdef MEM_ACCESS_VERIFY_EN
            wdata_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rw_q    <= rw_d;
            in_q    <= in_d;
            rdata_q <= rdata_d;
`ifdef MEM_ACCESS_VERIFY_EN
            wdata_q <= wdata_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
`ifdef MEM_ACCESS_VERIFY_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    assign cell_select = sel_q;
    assign cell_rw     = rw_q;
    assign cell_in     = in_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with a behavioural cell array
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int ROWS   = 2**ADDR_W;
`ifdef MEM_ACCESS_VERIFY_EN
    localparam int WLAT = 4;
`else
    localparam int WLAT = 2;
`endif
    localparam int RLAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [ROWS-1:0]   cell_select;
    logic              cell_rw;
    logic [DATA_W-1:0] cell_in;
    logic [DATA_W-1:0] cell_out;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cell_select (cell_select),
        .cell_rw     (cell_rw),
        .cell_in     (cell_in),
        .cell_out    (cell_out)
    );

    always #5 clk = ~clk;

    // Behavioural bit-cell array: write latches on select & ~rw, read registers select & rw & stored.
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] read_or;
    logic [DATA_W-1:0] cell_out_r = '0;
    logic              force_zero = 1'b0;

    always_comb begin
        read_or = '0;
        for (int r = 0; r < ROWS; r++)
            if (cell_select[r] && cell_rw == RW_READ) read_or = read_or | mem[r];
    end

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            if (cell_select[r] && cell_rw == RW_WRITE) mem[r] <= cell_in;
        cell_out_r <= read_or;
    end

    assign cell_out = force_zero ? '0 : cell_out_r;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Row selects must never be multi-hot and must be clear whenever idle or responding.
    always @(negedge clk) begin
        if (!rst) begin
            check("select_onehot0", 32'($countones(cell_select) <= 1), 32'd1);
            if (bus.req_ready || bus.rsp_valid)
                check("select_clear_idle_resp", 32'(cell_select), 32'd0);
        end
    end

    logic [DATA_W:0] sb [$];

    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                          input logic exp_err, input int stall);
        int n;
        logic [DATA_W:0] exp;
        logic [DATA_W-1:0] held;
        check("req_ready_before", 32'(bus.req_ready), 32'd1);
        sb.push_back({exp_err, exp_rdata});
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = (stall == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(we ? "write_latency" : "read_latency", 32'(n), 32'(we ? WLAT : RLAT));
        exp = sb.pop_front();
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp[DATA_W-1:0]));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp[DATA_W]));
        check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
        held = bus.rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_rsp_rdata", 32'(bus.rsp_rdata), 32'(held));
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("after_req_ready", 32'(bus.req_ready), 32'd1);
        check("after_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("after_rsp_err", 32'(bus.rsp_err), 32'd0);
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        int                stall;
    } vec_t;

    vec_t vecs [$];

    initial begin
        vecs.push_back('{1'b1, 4'd3,  8'hA5, 8'h00, 0});
        vecs.push_back('{1'b0, 4'd3,  8'h00, 8'hA5, 0});
        vecs.push_back('{1'b1, 4'd0,  8'h0F, 8'h00, 0});
        vecs.push_back('{1'b1, 4'd15, 8'hF0, 8'h00, 0});
        vecs.push_back('{1'b0, 4'd0,  8'h00, 8'h0F, 0});
        vecs.push_back('{1'b0, 4'd15, 8'h00, 8'hF0, 0});
        vecs.push_back('{1'b0, 4'd3,  8'h00, 8'hA5, 5});
        vecs.push_back('{1'b1, 4'd7,  8'hFF, 8'h00, 0});
        vecs.push_back('{1'b1, 4'd7,  8'h00, 8'h00, 0});
        vecs.push_back('{1'b0, 4'd7,  8'h00, 8'h00, 0});
        vecs.push_back('{1'b1, 4'd5,  8'h5A, 8'h00, 0});

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_cell_select", 32'(cell_select), 32'd0);
        check("rst_cell_rw", 32'(cell_rw), 32'd1);
        check("rst_cell_in", 32'(cell_in), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0, vecs[i].stall);

        // Reset while a read of row 5 sits in RDCAP.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_cell_select", 32'(cell_select), 32'd0);
        check("midrst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        do_req(1'b0, 4'd5, 8'h00, 8'h5A, 1'b0, 0);

        // Reset during ACCESS of a write: the cell write on that edge still lands.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd9;
        bus.req_wdata = 8'h99;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("accrst_cell_select", 32'(cell_select), 32'd0);
        check("accrst_req_ready", 32'(bus.req_ready), 32'd1);
        do_req(1'b0, 4'd9, 8'h00, 8'h99, 1'b0, 0);

`ifdef MEM_ACCESS_VERIFY_EN
        do_req(1'b1, 4'd4, 8'h3C, 8'h00, 1'b0, 0);
        force_zero = 1'b1;
        do_req(1'b1, 4'd4, 8'h3C, 8'h00, 1'b1, 0);
        force_zero = 1'b0;
        do_req(1'b0, 4'd4, 8'h00, 8'h3C, 1'b0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
